div_req_ctrl: RTL

DIV_REQ_CTRL -- requirements
Module: div_req_ctrl

---
 rtl/div_req_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/div_req_ctrl.sv
// Request/response front end for an iterative divider: captures one request,
// resolves divide-by-zero and signed overflow locally, otherwise launches the divider.
module div_req_ctrl #(
    parameter int unsigned PARALLELISM = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [3:0]             req_tag,
    input  logic [PARALLELISM-1:0] req_a,
    input  logic [PARALLELISM-1:0] req_b,

    output logic                   div_valid,
    output logic                   div_usigned,
    output logic [PARALLELISM-1:0] div_dividend,
    output logic [PARALLELISM-1:0] div_divisor,
    input  logic [PARALLELISM-1:0] div_quotient,
    input  logic [PARALLELISM-1:0] div_reminder,
    input  logic                   div_res_ready,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [PARALLELISM-1:0] rsp_data,
    output logic [3:0]             rsp_tag,
    output logic                   rsp_special
);

    localparam int unsigned W = PARALLELISM;
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [3:0]     tag_q, tag_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic           rsp_special_q, rsp_special_d;

    logic           b_zero;
    logic           signed_ovf;

    // Special cases are decided from the live request so the response is ready one cycle later.
    assign b_zero     = (req_b == '0);
    assign signed_ovf = !req_op[0] && (req_a == INT_MIN) && (req_b == '1);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        tag_d         = tag_q;
        a_d           = a_q;
        b_d           = b_q;
        rsp_data_d    = rsp_data_q;
        rsp_special_d = rsp_special_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op;
                    tag_d = req_tag;
                    a_d   = req_a;
                    b_d   = req_b;
                    if (b_zero) begin
                        rsp_data_d    = req_op[1] ? req_a : '1;
                        rsp_special_d = 1'b1;
                        state_d       = ST_RESP;
                    end else if (signed_ovf) begin
                        rsp_data_d    = req_op[1] ? '0 : req_a;
                        rsp_special_d = 1'b1;
                        state_d       = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_res_ready) begin
                    rsp_data_d    = op_q[1] ? div_reminder : div_quotient;
                    rsp_special_d = 1'b0;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            tag_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            rsp_data_q    <= '0;
            rsp_special_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rsp_data_q    <= rsp_data_d;
            rsp_special_q <= rsp_special_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign div_valid    = (state_q == ST_LAUNCH);
    assign rsp_valid    = (state_q == ST_RESP);
    assign div_usigned  = op_q[0];
    assign div_dividend = a_q;
    assign div_divisor  = b_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = tag_q;
    assign rsp_special  = rsp_special_q;

endmodule
